// File: rtl/bus_arbiter2.sv
// Two-requester arbiter for a shared payload mux with a bounded burst length.
// Alternates fairly on contention and registers the selected word plus a valid flag.
module bus_arbiter2 #(
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAXBURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        G0,
        G1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            last_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            sel_nxt;
    logic            burst_done;
    logic            entry;
    logic            xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        burst_done = (cnt == CMAX);
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? G0 : G1;
                else if (req0)
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
            end
            G0: begin
                if (req0) begin
                    if (burst_done && req1)
                        state_nxt = G1;
                end else begin
                    state_nxt = req1 ? G1 : IDLE;
                end
            end
            G1: begin
                if (req1) begin
                    if (burst_done && req0)
                        state_nxt = G0;
                end else begin
                    state_nxt = req0 ? G0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A grant entry is any move into G0/G1 from a different state, including a direct handover.
    always_comb begin
        entry    = (state_nxt != state) && (state_nxt != IDLE);
        cnt_nxt  = cnt;
        last_nxt = last;
        sel_nxt  = sel;
        if (entry) begin
            cnt_nxt  = '0;
            last_nxt = (state_nxt == G1);
        end else if (state_nxt != IDLE && cnt != CMAX) begin
            cnt_nxt = cnt + CW'(1);
        end
        if (state_nxt == G1)
            sel_nxt = 1'b1;
        else if (state_nxt == G0)
            sel_nxt = 1'b0;
    end

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);
    assign xfer = (gnt0 && req0) || (gnt1 && req1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer)
                out_data <= gnt1 ? d1 : d0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: expected grants checked per cycle, expected
// transfers queued and matched by an independent output monitor.
module tb_bus_arbiter2;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        gnt0;
    logic        gnt1;
    logic        sel;
    logic [31:0] out_data;
    logic        out_valid;

    int tests;
    int fails;
    logic [31:0] expq[$];

    bus_arbiter2 #(.WIDTH(32), .MAXBURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .d0       (d0),
        .d1       (d1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check grant/sel mid-cycle, queue the transfer this cycle should make.
    task automatic cyc(input logic r0, input logic r1, input logic [31:0] a, input logic [31:0] b,
                       input logic eg0, input logic eg1, input logic esel);
        req0 = r0;
        req1 = r1;
        d0   = a;
        d1   = b;
        @(negedge clk);
        chk("grant", {29'd0, gnt0, gnt1, sel}, {29'd0, eg0, eg1, esel});
        if ((eg0 && r0) || (eg1 && r1))
            expq.push_back(eg1 ? b : a);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every presented word must match the oldest expected transfer.
    always @(negedge clk) begin
        if (out_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h expected no transfer at %0t", out_data, $time);
            end else begin
                chk("out_data", out_data, expq.pop_front());
            end
        end
    end

    // Mutual exclusion and sel/grant consistency every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (gnt0 || gnt1)
                chk("sel_vs_gnt1", {31'd0, sel}, {31'd0, gnt1});
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish by 50000");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        d0    = '0;
        d1    = '0;
        #1;
        chk("reset_state", {28'd0, gnt0, gnt1, sel, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester 0, held beyond the burst limit with no competitor.
        cyc(1, 0, 32'hA5A5A5A5, 32'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(1, 0, 32'hA5A5A5A5, 32'h0, 1, 0, 0);
        cyc(0, 0, 32'hA5A5A5A5, 32'h0, 1, 0, 0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // Requester 1 one-cycle pulse; sel keeps 1 once back in IDLE.
        cyc(0, 1, 32'h0, 32'h11111111, 0, 0, 0);
        cyc(0, 0, 32'h0, 32'h11111111, 0, 1, 1);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 1);

        // Both requesting: bursts of four alternate with no IDLE gap.
        cyc(1, 1, 32'h0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 18; i++) begin
            logic g1;
            g1 = ((i / 4) % 2) == 1;
            cyc(1, 1, 32'h100 + i, 32'h200 + i, !g1, g1, g1);
        end

        // G0 owner drops after two cycles: direct handover, G1 burst counts from zero.
        cyc(0, 1, 32'h300, 32'h400, 1, 0, 0);
        cyc(0, 1, 32'h301, 32'h401, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 32'h302 + i, 32'h402 + i, 0, 1, 1);
        cyc(1, 1, 32'h305, 32'h405, 1, 0, 0);
        cyc(0, 0, 32'h306, 32'h406, 1, 0, 0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0);

        // Reset asserted between edges during a G1 burst.
        cyc(0, 1, 32'h0, 32'h500, 0, 0, 0);
        cyc(0, 1, 32'h0, 32'h501, 0, 1, 1);
        cyc(0, 1, 32'h0, 32'h502, 0, 1, 1);
        req0 = 1'b1;
        req1 = 1'b1;
        d0   = 32'h600;
        d1   = 32'h503;
        @(negedge clk);
        chk("pre_reset_grant", {30'd0, gnt1, sel}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_ctl", {28'd0, gnt0, gnt1, sel, out_valid}, 32'd0);
        chk("async_reset_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 1, 32'h700, 32'h800, 0, 0, 0);
        cyc(1, 1, 32'h701, 32'h801, 1, 0, 0);
        cyc(0, 0, 32'h702, 32'h802, 1, 0, 0);
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 0);

        @(negedge clk);
        chk("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 Parameter WIDTH, default 32: data width of each requester's payload and of the shared output.
REQ-002 Parameter MAXBURST, default 4: maximum consecutive granted cycles before a requester must yield to a waiting peer; legal range 2..16.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port req0  input  1: requester 0 asks for the shared mux path.
REQ-006 Port req1  input  1: requester 1 asks for the shared mux path.
REQ-007 Port d0  input  WIDTH: requester 0 payload, mux input a.
REQ-008 Port d1  input  WIDTH: requester 1 payload, mux input b.
REQ-009 Port gnt0  output  1: requester 0 owns the path this cycle (registered).
REQ-010 Port gnt1  output  1: requester 1 owns the path this cycle (registered).
REQ-011 Port sel  output  1: mux select; 0 selects d0, 1 selects d1 (registered).
REQ-012 Port out_data  output  WIDTH: registered copy of the selected payload.
REQ-013 Port out_valid  output  1: out_data holds a transferred word.

Function
REQ-014 FSM states: IDLE, G0, G1; gnt0=1 only in G0, gnt1=1 only in G1, never both.
REQ-015 sel SHALL be 1 in G1, 0 in G0, and hold its last value in IDLE.
REQ-016 Internal last-served pointer `last` (1 bit) SHALL record the most recently granted requester; updated on every entry to G0 (last=0) or G1 (last=1).
REQ-017 IDLE: req0 only -> G0; req1 only -> G1; both -> grant the requester not equal to `last`; none -> stay IDLE.
REQ-018 Grant latency: a request sampled at edge N in IDLE SHALL produce the grant after edge N (one cycle).
REQ-019 Burst counter `cnt` (ceil(log2(MAXBURST)) bits) SHALL clear to 0 on every grant entry and increment once per cycle in G0/G1, saturating at MAXBURST-1.
REQ-020 In Gx with reqx=1: if cnt==MAXBURST-1 and the other req=1 -> switch directly to the other grant state (no IDLE bubble); otherwise stay.
REQ-021 In Gx with reqx=0: other req=1 -> switch directly to the other grant state; otherwise -> IDLE.
REQ-022 Saturated cnt with no competing request SHALL leave the owner granted indefinitely.
REQ-023 Transfer: on each edge where (gnt0&req0) or (gnt1&req1), out_data <= selected payload and out_valid <= 1; otherwise out_valid <= 0 and out_data holds.
REQ-024 out_data/out_valid latency: one cycle after the granted cycle in which the payload was presented.
REQ-025 Requests dropped during a granted cycle SHALL produce no transfer for that cycle (out_valid=0 next cycle).
REQ-026 Simultaneous req0 and req1 rising in IDLE after reset SHALL grant requester 0 first.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force: state IDLE, gnt0=0, gnt1=0, sel=0, out_data=0, out_valid=0, cnt=0, last=1.
REQ-028 Reset asserted mid-burst SHALL abort the grant with no further transfer; after release, arbitration restarts as from IDLE with last=1.
REQ-029 First rising edge after rst deasserts SHALL be a normal evaluation edge.

Verification
REQ-030 Reset then req0=1, d0=0xA5A5A5A5 held, req1=0 -> gnt0=1 after 1 edge, out_valid=1 and out_data=0xA5A5A5A5 after 2 edges; gnt0 stays 1 beyond 4 cycles.
REQ-031 Reset then req0=req1=1 held, MAXBURST=4 -> grant sequence G0 x4, G1 x4, G0 x4; sel toggles 0,1,0 with no IDLE cycle between bursts.
REQ-032 G0 owner drops req0 after 2 cycles with req1=1 -> G1 on next edge, cnt restarts, out_data switches to d1 one cycle later.
REQ-033 Single requester req1 pulses 1 cycle -> G1 one cycle, then IDLE; out_valid=0 if req1 low in the granted cycle.
REQ-034 Assert rst asynchronously mid-G1 burst (between edges) -> gnt1, sel, out_valid, out_data go 0 immediately; after release with both requesting, G0 granted first.
REQ-035 Every cycle checker: gnt0&gnt1 never 1; sel equals gnt1 whenever a grant is active.
